serial_frame_receiver: RTL and testbench

Receive end of the GFX serial frontend link. Deserialises 8N1 bytes from the serial line and detects a frame sync byte. Packs byte pairs into 16-bit words and writes them sequentially into VRAM through a MEMC-style port. A lock output takes the VRAM mux for the duration of a frame, so a host-side board can push a full framebuffer into VRAM over the same link format the GPU transmits.

---
 rtl/serial_frame_receiver.sv | 221 ++++++++++++++++++++++
 tb/tb_serial_frame_receiver.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_receiver.sv
// Serial 8N1 frame receiver: deserialises bytes, finds the sync byte and writes 16-bit words into VRAM.
// Optional trailing XOR checksum byte is built when FRAME_CHECKSUM_EN is defined.
module serial_frame_receiver #(
   parameter int          CLKS_PER_BIT = 434,
   parameter int          FRAME_WORDS  = 1024,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        IN_SERIAL_RX,
   output logic        RAM_ENABLE,
   output logic        RAM_WRITE,
   output logic [9:0]  RAM_ADDR,
   output logic [15:0] RAM_DATA_W,
   output logic        RAM_LOCK,
   output logic        SIG_FRAME_DONE,
   output logic        SIG_ERROR
);
   // state   | meaning
   // B_IDLE  | line idle (or waiting for high after a framing error)
   // B_START | half-bit wait, then confirm start bit
   // B_DATA  | sampling 8 data bits, LSB first
   // B_STOP  | sampling stop bit
   // F_WAIT_SYNC | no frame, looking for SYNC_BYTE
   // F_HI / F_LO | collecting high / low byte of a word
   // F_WRITE     | one-cycle VRAM write strobe
   // F_CHECK     | waiting for checksum byte (FRAME_CHECKSUM_EN only)
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [9:0]    LAST_ADDR = 10'(FRAME_WORDS - 1);

   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
   typedef enum logic [2:0] {F_WAIT_SYNC, F_HI, F_LO, F_WRITE
`ifdef FRAME_CHECKSUM_EN
      , F_CHECK
`endif
   } fstate_t;

   logic          rx_meta_q, rx_sync_q;
   bstate_t       bstate_q, bstate_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          err_wait_q, err_wait_d;
   logic          byte_valid, byte_err;

   fstate_t       fstate_q, fstate_d;
   logic [9:0]    addr_q, addr_d;
   logic [15:0]   word_q, word_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
`ifdef FRAME_CHECKSUM_EN
   logic [7:0]    acc_q, acc_d;
`endif

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         bstate_q   <= B_IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         err_wait_q <= 1'b0;
         fstate_q   <= F_WAIT_SYNC;
         addr_q     <= '0;
         word_q     <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
         acc_q      <= '0;
`endif
      end else begin
         rx_meta_q  <= IN_SERIAL_RX;
         rx_sync_q  <= rx_meta_q;
         bstate_q   <= bstate_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         err_wait_q <= err_wait_d;
         fstate_q   <= fstate_d;
         addr_q     <= addr_d;
         word_q     <= word_d;
         done_q     <= done_d;
         err_q      <= err_d;
`ifdef FRAME_CHECKSUM_EN
         acc_q      <= acc_d;
`endif
      end
   end

   always_comb begin
      bstate_d   = bstate_q;
      cnt_d      = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      err_wait_d = err_wait_q;
      byte_valid = 1'b0;
      byte_err   = 1'b0;
      case (bstate_q)
         B_IDLE: begin
            if (err_wait_q) begin
               if (rx_sync_q) err_wait_d = 1'b0;
            end else if (!rx_sync_q) begin
               bstate_d = B_START;
               cnt_d    = HALF_LOAD;
            end
         end
         B_START: begin
            if (cnt_q == '0) begin
               if (!rx_sync_q) begin
                  bstate_d  = B_DATA;
                  cnt_d     = BIT_LOAD;
                  bit_idx_d = '0;
               end else begin
                  bstate_d = B_IDLE;
               end
            end
         end
         B_DATA: begin
            if (cnt_q == '0) begin
               shift_d   = {rx_sync_q, shift_q[7:1]};
               cnt_d     = BIT_LOAD;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) bstate_d = B_STOP;
            end
         end
         B_STOP: begin
            if (cnt_q == '0) begin
               bstate_d = B_IDLE;
               if (rx_sync_q) begin
                  byte_valid = 1'b1;
               end else begin
                  byte_err   = 1'b1;
                  err_wait_d = 1'b1;
               end
            end
         end
         default: bstate_d = B_IDLE;
      endcase
   end

   always_comb begin
      fstate_d = fstate_q;
      addr_d   = addr_q;
      word_d   = word_q;
      done_d   = 1'b0;
      err_d    = byte_err;
`ifdef FRAME_CHECKSUM_EN
      acc_d    = acc_q;
`endif
      case (fstate_q)
         F_WAIT_SYNC: begin
            if (byte_valid && shift_q == SYNC_BYTE) begin
               fstate_d = F_HI;
               addr_d   = '0;
`ifdef FRAME_CHECKSUM_EN
               acc_d    = '0;
`endif
            end
         end
         F_HI: begin
            if (byte_err) begin
               fstate_d = F_WAIT_SYNC;
            end else if (byte_valid) begin
               word_d[15:8] = shift_q;
               fstate_d     = F_LO;
`ifdef FRAME_CHECKSUM_EN
               acc_d        = acc_q ^ shift_q;
`endif
            end
         end
         F_LO: begin
            if (byte_err) begin
               fstate_d = F_WAIT_SYNC;
            end else if (byte_valid) begin
               word_d[7:0] = shift_q;
               fstate_d    = F_WRITE;
`ifdef FRAME_CHECKSUM_EN
               acc_d       = acc_q ^ shift_q;
`endif
            end
         end
         F_WRITE: begin
            // Counter holds on the last word so FRAME_WORDS=1024 never wraps.
            if (addr_q == LAST_ADDR) begin
`ifdef FRAME_CHECKSUM_EN
               fstate_d = F_CHECK;
`else
               fstate_d = F_WAIT_SYNC;
               done_d   = 1'b1;
`endif
            end else begin
               addr_d   = addr_q + 10'd1;
               fstate_d = F_HI;
            end
         end
`ifdef FRAME_CHECKSUM_EN
         F_CHECK: begin
            if (byte_err) begin
               fstate_d = F_WAIT_SYNC;
            end else if (byte_valid) begin
               fstate_d = F_WAIT_SYNC;
               if (shift_q == acc_q) done_d = 1'b1;
               else                  err_d  = 1'b1;
            end
         end
`endif
         default: fstate_d = F_WAIT_SYNC;
      endcase
   end

   assign RAM_ENABLE     = (fstate_q == F_WRITE);
   assign RAM_WRITE      = (fstate_q == F_WRITE);
   assign RAM_ADDR       = addr_q;
   assign RAM_DATA_W     = word_q;
   assign RAM_LOCK       = (fstate_q != F_WAIT_SYNC);
   assign SIG_FRAME_DONE = done_q;
   assign SIG_ERROR      = err_q;
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver (CLKS_PER_BIT=16, FRAME_WORDS=4).
// Honors FRAME_CHECKSUM_EN to append and test the checksum byte.
module tb_serial_frame_receiver;
   localparam int CPB = 16;
   localparam int FW  = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx = 1'b1;
   logic        ram_en, ram_we, lock, done, err;
   logic [9:0]  addr;
   logic [15:0] wdata;

   int n_checks = 0;
   int n_fail   = 0;

   int          wr_cnt, done_cnt, err_cnt, lock_seen, we_diff;
   logic [9:0]  wr_addr [8];
   logic [15:0] wr_data [8];
   logic        wr_lock [8];

   logic [7:0]  fb [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
   logic [7:0]  good_ck;

   serial_frame_receiver #(.CLKS_PER_BIT(CPB), .FRAME_WORDS(FW), .SYNC_BYTE(8'hA5)) dut (
      .CLK(clk), .RESET(rst_n), .IN_SERIAL_RX(rx),
      .RAM_ENABLE(ram_en), .RAM_WRITE(ram_we), .RAM_ADDR(addr), .RAM_DATA_W(wdata),
      .RAM_LOCK(lock), .SIG_FRAME_DONE(done), .SIG_ERROR(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ram_en) begin
         if (wr_cnt < 8) begin
            wr_addr[wr_cnt] = addr;
            wr_data[wr_cnt] = wdata;
            wr_lock[wr_cnt] = lock;
         end
         wr_cnt++;
      end
      if (ram_en !== ram_we) we_diff++;
      if (done) done_cnt++;
      if (err)  err_cnt++;
      if (lock) lock_seen = 1;
   end

   task automatic clear_mon();
      wr_cnt = 0; done_cnt = 0; err_cnt = 0; lock_seen = 0; we_diff = 0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop_bit);
      rx = 1'b1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] ck_flip);
      send_byte(8'hA5, 1'b1);
      for (int i = 0; i < 8; i++) send_byte(fb[i], 1'b1);
`ifdef FRAME_CHECKSUM_EN
      send_byte(good_ck ^ ck_flip, 1'b1);
`else
      if (ck_flip != 8'h00) idle(1);
`endif
      idle(3 * CPB);
   endtask

   task automatic check_frame(input string tag);
      check({tag, "_wr_cnt"}, wr_cnt, FW);
      for (int i = 0; i < FW; i++) begin
         check({tag, "_addr"}, {22'd0, wr_addr[i]}, i);
         check({tag, "_data"}, {16'd0, wr_data[i]}, {16'd0, fb[2*i], fb[2*i+1]});
         check({tag, "_lock_at_wr"}, {31'd0, wr_lock[i]}, 1);
      end
      check({tag, "_done"}, done_cnt, 1);
      check({tag, "_err"}, err_cnt, 0);
      check({tag, "_we"}, we_diff, 0);
      check({tag, "_lock_after"}, {31'd0, lock}, 0);
   endtask

   initial begin
      good_ck = 8'h00;
      for (int i = 0; i < 8; i++) good_ck = good_ck ^ fb[i];
      clear_mon();
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {ram_en, ram_we, lock, done, err, addr, wdata},
            {5'b0, 10'd0, 16'd0});
      rst_n = 1'b1;
      idle(4);

      // bytes with no sync byte
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      idle(2 * CPB);
      check("nosync_writes", wr_cnt, 0);
      check("nosync_lock", lock_seen, 0);

      // full frame
      clear_mon();
      send_byte(8'hA5, 1'b1);
      idle(CPB);
      check("sync_lock_high", {31'd0, lock}, 1);
      for (int i = 0; i < 8; i++) send_byte(fb[i], 1'b1);
`ifdef FRAME_CHECKSUM_EN
      send_byte(good_ck, 1'b1);
`endif
      idle(3 * CPB);
      check_frame("frame1");

      // short glitch on idle line
      clear_mon();
      rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      idle(3 * CPB);
      check("glitch_err", err_cnt, 0);
      check("glitch_lock", lock_seen, 0);
      send_frame(8'h00);
      check_frame("after_glitch");

      // framing error mid-frame; sync value as data
      clear_mon();
      send_byte(8'hA5, 1'b1);
      send_byte(8'hA5, 1'b1);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h11, 1'b0);
      idle(3 * CPB);
      check("ferr_err", err_cnt, 1);
      check("ferr_lock", {31'd0, lock}, 0);
      check("ferr_wr_cnt", wr_cnt, 1);
      check("ferr_data", {16'd0, wr_data[0]}, 32'h0000A5A5);
      check("ferr_done", done_cnt, 0);
      clear_mon();
      send_frame(8'h00);
      check_frame("after_ferr");

      // reset mid-word after two words
      clear_mon();
      send_byte(8'hA5, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(fb[i], 1'b1);
      check("rst_pre_writes", wr_cnt, 2);
      drive_bit(1'b0);
      drive_bit(1'b1);
      rst_n = 1'b0;
      #2;
      check("rst_mid_outputs", {ram_en, ram_we, lock, done, err, addr, wdata},
            {5'b0, 10'd0, 16'd0});
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(12 * CPB);
      clear_mon();
      send_frame(8'h00);
      check_frame("after_rst");

`ifdef FRAME_CHECKSUM_EN
      clear_mon();
      send_frame(8'h01);
      check("bad_ck_err", err_cnt, 1);
      check("bad_ck_done", done_cnt, 0);
      check("bad_ck_lock", {31'd0, lock}, 0);
      check("bad_ck_writes", wr_cnt, FW);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
